// File: rtl/mem_defs_pkg.sv
// Shared definitions for the SRAM arbiter: op encodings, FSM states, byte-enable constants.
package mem_defs;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_LB   = 4'b1001;
    localparam logic [3:0] OP_LBU  = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1100;
    localparam logic [3:0] OP_SB   = 4'b1101;

    localparam logic [3:0] BE_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Undefined encodings with bit3 set behave like OP_NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB};
    endfunction

    function automatic logic is_write(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// Byte-lane steering: store byte enables and lane replication, load byte extraction and extension.
module byte_lane
    import mem_defs::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be_n,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0] sel_byte;

    assign sel_byte = read_data[{offset, 3'b000} +: 8];

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        be_n       = 4'b0000;
        write_data = store_data;
        load_data  = read_data;
        case (op)
            OP_SB: begin
                be_n       = ~(4'b0001 << offset);
                write_data = {4{store_data[7:0]}};
            end
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'h000000, sel_byte};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single external SRAM between instruction fetch and the MEM-stage load/store unit.
module mem_arbiter
    import mem_defs::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ifOp_i,
    input  logic [31:0]       ifAddr_i,
    input  logic [3:0]        memOp_i,
    input  logic [31:0]       memAddr_i,
    input  logic [31:0]       memData_i,
    output logic [31:0]       inst_o,
    output logic              instValid_o,
    output logic [31:0]       memData_o,
    output logic              memValid_o,
    output logic              stallReq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_dataOe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        cur_op;
    logic [ADDR_W+1:0] cur_addr;
    logic [31:0]       cur_data;
    logic              cur_fetch;
    logic              pend_valid;
    logic [ADDR_W+1:0] pend_addr;

    logic if_req, mem_req, if_new, mem_new, take_pend, start, last_beat, cur_write;
    logic [3:0]  lane_be_n;
    logic [31:0] lane_wdata, lane_load;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{ifAddr_i[31:ADDR_W+2], memAddr_i[31:ADDR_W+2]};

    assign if_req    = (ifOp_i == OP_LW);
    assign mem_req   = is_mem_op(memOp_i);
    assign cur_write = is_write(cur_op);
    assign last_beat = (state == ST_ACCESS) && (cnt == '0);
    assign take_pend = (state == ST_DONE) && pend_valid;
    assign start     = if_new || mem_new || take_pend;

    // In DONE the source just served still presents its old op until the pipeline
    // advances at the end of this cycle, so only the other source counts as new.
    always_comb begin
        if_new  = 1'b0;
        mem_new = 1'b0;
        if (state == ST_IDLE) begin
            mem_new = mem_req;
            if_new  = if_req && !mem_req;
        end else if (state == ST_DONE && !pend_valid) begin
            mem_new = mem_req && cur_fetch;
            if_new  = if_req && !cur_fetch;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt == '0) state_next = ST_DONE;
            ST_DONE:   state_next = start ? ST_ACCESS : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_op     <= OP_NONE;
            cur_addr   <= '0;
            cur_data   <= '0;
            cur_fetch  <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            inst_o     <= '0;
            memData_o  <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                cnt <= CNT_LOAD;
                if (take_pend) begin
                    cur_op     <= OP_LW;
                    cur_addr   <= pend_addr;
                    cur_fetch  <= 1'b1;
                    pend_valid <= 1'b0;
                end else if (mem_new) begin
                    cur_op    <= memOp_i;
                    cur_addr  <= memAddr_i[ADDR_W+1:0];
                    cur_data  <= memData_i;
                    cur_fetch <= 1'b0;
                    // A fetch arriving together with a data access waits its turn.
                    if (state == ST_IDLE && if_req) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ifAddr_i[ADDR_W+1:0];
                    end
                end else begin
                    cur_op    <= OP_LW;
                    cur_addr  <= ifAddr_i[ADDR_W+1:0];
                    cur_fetch <= 1'b1;
                end
            end else if (state == ST_ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (last_beat && !cur_write) begin
                if (cur_fetch) inst_o    <= lane_load;
                else           memData_o <= lane_load;
            end
        end
    end

    byte_lane u_byte_lane (
        .op         (cur_op),
        .offset     (cur_addr[1:0]),
        .store_data (cur_data),
        .read_data  (sram_data_i),
        .be_n       (lane_be_n),
        .write_data (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        sram_ce_n_o   = (state != ST_ACCESS);
        sram_oe_n_o   = !((state == ST_ACCESS) && !cur_write);
        sram_we_n_o   = !((state == ST_ACCESS) && cur_write);
        sram_dataOe_o = (state == ST_ACCESS) && cur_write;
        sram_be_n_o   = BE_NONE;
        if (state == ST_ACCESS) sram_be_n_o = cur_write ? lane_be_n : 4'b0000;
    end

    assign sram_addr_o = cur_addr[ADDR_W+1:2];
    assign sram_data_o = lane_wdata;
    assign instValid_o = (state == ST_DONE) && cur_fetch;
    assign memValid_o  = (state == ST_DONE) && !cur_fetch;
    // Inputs stay live during reset, so the stall request is masked explicitly.
    assign stallReq_o  = rst && ((state == ST_ACCESS) || start);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM model, result scoreboard and per-cycle strobe logs.
module tb_mem_arbiter;
    import mem_defs::*;

    localparam int WAIT_CYCLES = 2;
    localparam int ADDR_W      = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        ifOp = OP_NONE, memOp = OP_NONE;
    logic [31:0]       ifAddr = '0, memAddr = '0, memData = '0;
    logic [31:0]       inst, memData_r, sram_wdata, sram_rdata;
    logic              instValid, memValid, stallReq, sram_doe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_be_n;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        fetch;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] sram [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    logic [15:0] log_stall, log_ce, log_oe, log_we, log_doe, log_iv, log_mv;
    logic [31:0] addr_log [16];
    logic [3:0]  be_log [16];
    logic [31:0] wd_log [16];

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifOp_i        (ifOp),
        .ifAddr_i      (ifAddr),
        .memOp_i       (memOp),
        .memAddr_i     (memAddr),
        .memData_i     (memData),
        .inst_o        (inst),
        .instValid_o   (instValid),
        .memData_o     (memData_r),
        .memValid_o    (memValid),
        .stallReq_o    (stallReq),
        .sram_addr_o   (sram_addr),
        .sram_data_o   (sram_wdata),
        .sram_data_i   (sram_rdata),
        .sram_dataOe_o (sram_doe),
        .sram_ce_n_o   (sram_ce_n),
        .sram_oe_n_o   (sram_oe_n),
        .sram_we_n_o   (sram_we_n),
        .sram_be_n_o   (sram_be_n)
    );

    assign sram_rdata = sram[sram_addr[7:0]];

    always @(posedge clk) begin
        if (poke_en) begin
            sram[poke_addr] <= poke_data;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Scoreboard: results are popped in completion order when a valid pulse appears.
    always @(negedge clk) begin
        if (rst && (instValid || memValid)) begin
            check("sb_onehot", {31'b0, instValid & memValid}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_source", {31'b0, instValid}, {31'b0, e.fetch});
                check("sb_data", instValid ? inst : memData_r, e.data);
            end
        end
    end

    // Logs n cycles; cycle 0 is the one already in progress. Ops drop at the start of the given cycle.
    task automatic observe(input int n, input int if_drop, input int mem_drop);
        log_stall = '0; log_ce = '0; log_oe = '0; log_we = '0;
        log_doe = '0; log_iv = '0; log_mv = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            log_stall[k] = stallReq;
            log_ce[k]    = ~sram_ce_n;
            log_oe[k]    = ~sram_oe_n;
            log_we[k]    = ~sram_we_n;
            log_doe[k]   = sram_doe;
            log_iv[k]    = instValid;
            log_mv[k]    = memValid;
            addr_log[k]  = 32'(sram_addr);
            be_log[k]    = sram_be_n;
            wd_log[k]    = sram_wdata;
            @(posedge clk);
            #1;
            if (k + 1 == if_drop)  ifOp  = OP_NONE;
            if (k + 1 == mem_drop) memOp = OP_NONE;
        end
    endtask

    task automatic issue_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        memOp   = op;
        memAddr = a;
        memData = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with live requests on both ports.
        ifOp = OP_LW; ifAddr = 32'h10;
        issue_mem(OP_SW, 32'h30, 32'h55);
        poke(8'd4,    32'h24020005);
        poke(8'd5,    32'h11112222);
        poke(8'd6,    32'hDEADBEEF);
        poke(8'd8,    32'hCAFEF00D);
        poke(8'd12,   32'h00000000);
        poke(8'h40,   32'h11223344);
        @(negedge clk);
        check("rst_strobes", {24'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_doe, sram_be_n}, 32'h000000EF);
        check("rst_stall_valid", {29'b0, stallReq, instValid, memValid}, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        check("rst_results", inst | memData_r, 32'd0);

        // 1: single fetch after reset release.
        @(posedge clk);
        #1;
        memOp = OP_NONE;
        rst   = 1'b1;
        sb.push_back('{fetch: 1'b1, data: 32'h24020005});
        observe(6, 4, 0);
        check("t1_stall", 32'(log_stall), 32'b000111);
        check("t1_inst_valid", 32'(log_iv), 32'b001000);
        check("t1_oe_low", 32'(log_oe), 32'b000110);
        check("t1_ce_low", 32'(log_ce), 32'b000110);
        check("t1_addr", addr_log[1], 32'd4);

        // 2: data and fetch together; data first, fetch pending right after.
        ifOp = OP_LW; ifAddr = 32'h14;
        issue_mem(OP_LW, 32'h20, 32'h0);
        sb.push_back('{fetch: 1'b0, data: 32'hCAFEF00D});
        sb.push_back('{fetch: 1'b1, data: 32'h11112222});
        observe(8, 7, 4);
        check("t2_ce_low", 32'(log_ce), 32'b00110110);
        check("t2_data_addr", addr_log[1], 32'd8);
        check("t2_fetch_addr", addr_log[4], 32'd5);
        check("t2_mem_valid", 32'(log_mv), 32'b00001000);
        check("t2_inst_valid", 32'(log_iv), 32'b01000000);
        check("t2_stall", 32'(log_stall), 32'b00111111);

        // 3: store byte to lane 3; load result register must not change.
        issue_mem(OP_SB, 32'h103, 32'h000000AB);
        sb.push_back('{fetch: 1'b0, data: 32'hCAFEF00D});
        observe(5, 0, 4);
        check("t3_we_low", 32'(log_we), 32'b00110);
        check("t3_data_oe", 32'(log_doe), 32'b00110);
        check("t3_be_n", 32'(be_log[1]), 32'b0111);
        check("t3_wdata", wd_log[1], 32'hABABABAB);
        check("t3_mem_valid", 32'(log_mv), 32'b01000);
        check("t3_sram_word", sram[8'h40], 32'hAB223344);

        // 4: signed and unsigned byte loads from lane 2.
        poke(8'h40, 32'h00800000);
        issue_mem(OP_LB, 32'h102, 32'h0);
        sb.push_back('{fetch: 1'b0, data: 32'hFFFFFF80});
        observe(5, 0, 4);
        check("t4_lb_be_n", 32'(be_log[1]), 32'b0000);
        check("t4_lb_oe_low", 32'(log_oe), 32'b00110);
        issue_mem(OP_LBU, 32'h102, 32'h0);
        sb.push_back('{fetch: 1'b0, data: 32'h00000080});
        observe(5, 0, 4);
        check("t4_lbu_mem_valid", 32'(log_mv), 32'b01000);

        // 5: fetch op held for one cycle only.
        ifOp = OP_LW; ifAddr = 32'h18;
        sb.push_back('{fetch: 1'b1, data: 32'hDEADBEEF});
        observe(7, 1, 0);
        check("t5_ce_low", 32'(log_ce), 32'b0000110);
        check("t5_inst_valid", 32'(log_iv), 32'b0001000);
        check("t5_stall", 32'(log_stall), 32'b0000111);

        // 6: reset in the first ACCESS cycle of a store.
        issue_mem(OP_SW, 32'h30, 32'h55);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
        check("t6_stall", {31'b0, stallReq}, 32'd0);
        @(posedge clk);
        #1 memOp = OP_NONE;
        @(posedge clk);
        #1 rst = 1'b1;
        observe(4, 0, 0);
        check("t6_no_access", 32'(log_ce), 32'd0);
        check("t6_no_valid", 32'(log_iv | log_mv), 32'd0);
        check("t6_sram_untouched", sram[8'd12], 32'd0);

        // Recovery: a fresh load after the aborted store.
        issue_mem(OP_LW, 32'h20, 32'h0);
        sb.push_back('{fetch: 1'b0, data: 32'hCAFEF00D});
        observe(5, 0, 4);
        check("t7_mem_valid", 32'(log_mv), 32'b01000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 32-bit external SRAM between instruction fetch (PC address plus the 4-bit ramOp from the fetch register) and the MEM-stage load/store unit.
- Runs each access as a multi-cycle SRAM transaction.
- Gives data accesses priority over fetch.
- Raises stallReq_o to the pipeline stall controller while any request is outstanding.
- Returns the fetched instruction and the load data in registers.

Parameters:
WAIT_CYCLES, 2, SRAM access cycles per transaction (>=1)
ADDR_W, 20, SRAM word-address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ifOp_i  in  4  fetch op (OP_NONE / OP_LW)
ifAddr_i  in  32  fetch byte address (PC)
memOp_i  in  4  MEM-stage op
memAddr_i  in  32  data byte address
memData_i  in  32  store data
inst_o  out  32  last fetched instruction
instValid_o  out  1  1-cycle pulse, inst_o updated
memData_o  out  32  load result, sign- or zero-extended
memValid_o  out  1  1-cycle pulse, memData_o updated
stallReq_o  out  1  pipeline stall request
sram_addr_o  out  ADDR_W  word address
sram_data_o  out  32  write data
sram_data_i  in  32  read data
sram_dataOe_o  out  1  drive data bus
sram_ce_n_o  out  1  chip enable, low active
sram_oe_n_o  out  1  output enable, low active
sram_we_n_o  out  1  write enable, low active
sram_be_n_o  out  4  byte enables, low active

Behaviour:
Op encoding:
- bit3 = valid, bit2 = write.
- OP_NONE=0000, OP_LW=1000, OP_LB=1001, OP_LBU=1010, OP_SW=1100, OP_SB=1101.
- Other values with bit3 set are treated as OP_NONE.

Reset (rst=0, async):
- State IDLE, counter 0.
- inst_o=0, memData_o=0, both valid pulses 0, stallReq_o=0.
- sram_ce_n/oe_n/we_n=1, be_n=1111, dataOe=0, addr=0, sram_data_o=0.
- Reset mid-transaction aborts it and drops all latched requests.

Request acceptance:
- A request is accepted in IDLE, or in DONE to allow back-to-back accesses.
- On acceptance, op, address and store data are latched. The request is then served even if the input op deasserts afterwards. Fetch drops its op while stalled, so this latching is required.

Arbitration:
- memOp valid wins over ifOp valid.
- If both are valid, the data access goes first. The fetch is latched as pending in the same cycle and starts directly after the data DONE.

FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS on accept. Counter loads WAIT_CYCLES-1.
- ACCESS:
  - ce_n=0, addr = latched addr[ADDR_W+1:2].
  - Read: oe_n=0, be_n=0000.
  - Write: we_n=0, dataOe=1, be_n per size.
  - Counter decrements each cycle. On the cycle the counter is 0, read data is captured into a result register and the FSM goes to DONE.
- DONE:
  - Strobes deasserted.
  - Exactly one valid pulse: instValid_o for a fetch, memValid_o for a load; a store pulses memValid_o with memData_o unchanged.
  - Next state is ACCESS if a pending or new request exists, otherwise IDLE.
- Latency: request seen in IDLE at cycle t -> valid pulse at cycle t+WAIT_CYCLES+1.

Byte handling:
- Word ops ignore addr[1:0].
- Load byte: byte selected by addr[1:0] (0 = bits 7:0, little-endian). LB sign-extends, LBU zero-extends.
- Store byte: the byte is replicated on all four lanes and be_n has a single 0 at lane addr[1:0].

stallReq_o:
- 1 whenever a valid input request is not yet completed, or the FSM is in ACCESS.
- 0 in DONE if nothing further is pending and no new valid input is present.
- 0 in IDLE with no requests.

Decomposition:
- Package mem_defs: op encodings, state encoding, BE_NONE=4'b1111.
- One sub-module, byte_lane: pure combinational; generates be_n and store replication, and does load extraction/extension.
- The FSM, counter and request latches stay in mem_arbiter.

Test Plan:
1. Reset release, ifOp=1000, ifAddr=0x10, SRAM word 4 = 0x24020005 -> stallReq high cycles 0..2; instValid pulse at cycle 3 with inst_o=0x24020005; addr=4 during ACCESS; oe_n low exactly 2 cycles.
2. Simultaneous memOp=1000 addr 0x20 and ifOp=1000 addr 0x14 -> data ACCESS first (addr 8), memValid at cycle 3, fetch ACCESS at cycles 4-5 (addr 5), instValid at cycle 6; stallReq continuously high through cycle 5.
3. SB addr 0x103, data 0x000000AB -> sram_data_o=0xABABABAB, be_n=0111, we_n low 2 cycles, dataOe high only in ACCESS.
4. LB/LBU at addr 0x102 with word 0x00800000 -> LB returns 0xFFFFFF80, LBU returns 0x00000080.
5. ifOp asserted 1 cycle then dropped to 0000 -> fetch still completes, instValid pulses once, no second access.
6. rst low during ACCESS cycle 1 -> immediately ce_n=we_n=oe_n=1, stallReq=0, no valid pulse after release until a new request arrives.
